mult_hilo_ctrl: RTL and testbench

MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

---
 rtl/mult_hilo_ctrl.sv | 151 +++++++++++++++
 tb/tb_mult_hilo_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_ctrl.sv
// HI/LO register file and sequencing controller for an external 2-stage multiplier.
// Optional multiply-accumulate (MADD/MADDU/MSUB/MSUBU) is enabled by defining MULT_HILO_ACCUM_EN.
module mult_hilo_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        cancel,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_sign,
    input  logic [63:0] mul_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_MTHI = 3'b010;

    state_t      state_q, state_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic        mul_sign_q, mul_sign_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        op_acc_q, op_acc_d;
`ifdef MULT_HILO_ACCUM_EN
    logic        op_sub_q, op_sub_d;
`endif

    logic        accept;
    logic        is_mt;
    logic        wb_fire;
    logic [63:0] hilo_cur;
    logic [63:0] wb_value;

    assign hilo_cur = {hi_q, lo_q};
    assign accept   = (state_q == S_IDLE) & req_valid & ~cancel;
    assign is_mt    = (req_op[2:1] == 2'b01);
    assign wb_fire  = (state_q == S_WB) & ~cancel;

    // Write-back value; without the accumulate option, op_acc ops leave HI/LO as is.
    always_comb begin
        wb_value = mul_result;
`ifdef MULT_HILO_ACCUM_EN
        if (op_acc_q) begin
            wb_value = op_sub_q ? (hilo_cur - mul_result) : (hilo_cur + mul_result);
        end
`else
        if (op_acc_q) begin
            wb_value = hilo_cur;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        mul_sign_d = mul_sign_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        op_acc_d   = op_acc_q;
`ifdef MULT_HILO_ACCUM_EN
        op_sub_d   = op_sub_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mt) begin
                        if (req_op == OP_MTHI) begin
                            hi_d = req_a;
                        end else begin
                            lo_d = req_a;
                        end
                    end else begin
                        mul_a_d    = req_a;
                        mul_b_d    = req_b;
                        // Even opcodes are the signed variants.
                        mul_sign_d = ~req_op[0];
                        op_acc_d   = req_op[2];
`ifdef MULT_HILO_ACCUM_EN
                        op_sub_d   = req_op[1];
`endif
                        state_d    = S_CALC;
                    end
                end
            end
            S_CALC: begin
                state_d = cancel ? S_IDLE : S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    hi_d = wb_value[63:32];
                    lo_d = wb_value[31:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            mul_a_q    <= 32'd0;
            mul_b_q    <= 32'd0;
            mul_sign_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            op_acc_q   <= 1'b0;
`ifdef MULT_HILO_ACCUM_EN
            op_sub_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_sign_q <= mul_sign_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            op_acc_q   <= op_acc_d;
`ifdef MULT_HILO_ACCUM_EN
            op_sub_q   <= op_sub_d;
`endif
        end
    end

    // done is gated by reset so a write-back discarded by reset never pulses.
    assign req_ready = (state_q == S_IDLE) & ~cancel;
    assign busy      = (state_q == S_CALC) | (state_q == S_WB);
    assign done      = resetn & ((accept & is_mt) | wb_fire);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_sign  = mul_sign_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Scoreboard bench for mult_hilo_ctrl with a behavioural 2-stage multiplier.
// Expectations follow MULT_HILO_ACCUM_EN when the bench is built with it defined.
module tb_mult_hilo_ctrl;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b010;
    localparam logic [2:0] OP_MTLO  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;
    localparam logic [2:0] OP_MSUB  = 3'b110;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        cancel;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_sign;
    logic [63:0] mul_result;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb[$];
    logic [63:0] last_exp;

    mult_hilo_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .cancel     (cancel),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_sign   (mul_sign),
        .mul_result (mul_result),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    // Multiplier: product of the operands presented in one cycle appears in the next.
    always @(posedge clk) begin
        if (mul_sign) begin
            mul_result <= $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
        end else begin
            mul_result <= {32'd0, mul_a} * {32'd0, mul_b};
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every done pulse pops one expectation, compared with HI/LO a cycle later.
    initial begin
        logic pending;
        logic [63:0] exp;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (pending) begin
                exp = sb.pop_front();
                check("sb_hilo", {hi, lo}, exp);
                pending = 1'b0;
            end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_done: got done=1 required no pending op");
                end else begin
                    pending = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required test completion");
        $fatal(1, "watchdog");
    end

    // Called just after a rising edge; returns just after the edge ending cycle T.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        check("ready_T", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
        sb.push_back(exp);
        last_exp = exp;
        issue(op, a, b);
        @(negedge clk);
        check("T1_busy_ready_done", {61'd0, busy, req_ready, done}, {61'd0, 3'b100});
        @(posedge clk);
        #1;
        @(negedge clk);
        check("T2_busy_ready_done", {61'd0, busy, req_ready, done}, {61'd0, 3'b101});
        @(posedge clk);
        #1;
        @(negedge clk);
        check("T3_busy_ready", {62'd0, busy, req_ready}, {62'd0, 2'b01});
        @(posedge clk);
        #1;
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
        logic [63:0] exp;
        exp = (op == OP_MTHI) ? {a, last_exp[31:0]} : {last_exp[63:32], a};
        sb.push_back(exp);
        last_exp  = exp;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = 32'h0;
        @(negedge clk);
        check("mt_done_T", {62'd0, done, busy}, {62'd0, 2'b10});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_a     = 32'h0;
        req_b     = 32'h0;
        cancel    = 1'b0;
        last_exp  = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_ready_busy_done", {61'd0, req_ready, busy, done}, {61'd0, 3'b100});
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_mul_regs", {31'd0, mul_sign, mul_a}, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("post_reset_ready_busy", {62'd0, req_ready, busy}, {62'd0, 2'b10});
        @(posedge clk);
        #1;

        run_mul(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 64'h00000001_FFFFFFFE);
        run_mul(OP_MULT,  32'hFFFF_FFFF, 32'h3, 64'hFFFFFFFF_FFFFFFFD);

        run_mt(OP_MTHI, 32'h1);
        run_mt(OP_MTLO, 32'hFFFF_FFFF);
`ifdef MULT_HILO_ACCUM_EN
        run_mul(OP_MADDU, 32'h1, 32'h1, 64'h00000002_00000000);
`else
        run_mul(OP_MADDU, 32'h1, 32'h1, 64'h00000001_FFFFFFFF);
`endif
        run_mt(OP_MTHI, 32'h1);
        run_mt(OP_MTLO, 32'hFFFF_FFFF);
`ifdef MULT_HILO_ACCUM_EN
        run_mul(OP_MSUB, 32'h1, 32'h1, 64'h00000001_FFFFFFFE);
`else
        run_mul(OP_MSUB, 32'h1, 32'h1, 64'h00000001_FFFFFFFF);
`endif

        run_mt(OP_MTHI, 32'h5);
        run_mt(OP_MTLO, 32'h5);
`ifdef MULT_HILO_ACCUM_EN
        run_mul(OP_MADD, 32'h2, 32'h3, 64'h00000005_0000000B);
`else
        run_mul(OP_MADD, 32'h2, 32'h3, 64'h00000005_00000005);
`endif

        // MULT with cancel pulsed in CALC.
        issue(OP_MULT, 32'h5, 32'h6);
        cancel = 1'b1;
        @(negedge clk);
        check("cancel_calc_done_busy", {62'd0, done, busy}, {62'd0, 2'b01});
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_next_ready_busy_done", {61'd0, req_ready, busy, done}, {61'd0, 3'b100});
        check("cancel_hilo_kept", {hi, lo}, last_exp);
        @(posedge clk);
        #1;

        // Cancel in IDLE blocks acceptance.
        req_valid = 1'b1;
        req_op    = OP_MTHI;
        req_a     = 32'hDEAD_BEEF;
        cancel    = 1'b1;
        @(negedge clk);
        check("idle_cancel_ready_done", {62'd0, req_ready, done}, 64'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cancel    = 1'b0;
        @(negedge clk);
        check("idle_cancel_hilo_kept", {hi, lo}, last_exp);
        @(posedge clk);
        #1;

        // Reset asserted during WB of a MULT.
        issue(OP_MULT, 32'h7, 32'h8);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        check("reset_in_wb_done", {63'd0, done}, 64'd0);
        @(posedge clk);
        #1;
        resetn   = 1'b1;
        last_exp = 64'd0;
        @(negedge clk);
        check("reset_in_wb_hilo", {hi, lo}, 64'd0);
        check("reset_in_wb_busy_ready", {62'd0, busy, req_ready}, {62'd0, 2'b01});
        @(posedge clk);
        #1;

        run_mul(OP_MULT, 32'h5, 32'h6, 64'h00000000_0000001E);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
